// File: rtl/ysyx_23060025_lsu_pkg.sv
// Shared types and constants for the split-capable load/store unit.
// Holds the FSM states, the access size codes and the load/store type table.
package ysyx_23060025_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef struct packed {
    logic [1:0] size;
    logic       sext;
  } mem_type_t;

  localparam mem_type_t LOAD_LB  = '{size: SIZE_B, sext: 1'b1};
  localparam mem_type_t LOAD_LBU = '{size: SIZE_B, sext: 1'b0};
  localparam mem_type_t LOAD_LH  = '{size: SIZE_H, sext: 1'b1};
  localparam mem_type_t LOAD_LHU = '{size: SIZE_H, sext: 1'b0};
  localparam mem_type_t LOAD_LW  = '{size: SIZE_W, sext: 1'b1};
  localparam mem_type_t LOAD_LWU = '{size: SIZE_W, sext: 1'b0};
  localparam mem_type_t LOAD_LD  = '{size: SIZE_D, sext: 1'b0};
  localparam mem_type_t STORE_SB = '{size: SIZE_B, sext: 1'b0};
  localparam mem_type_t STORE_SH = '{size: SIZE_H, sext: 1'b0};
  localparam mem_type_t STORE_SW = '{size: SIZE_W, sext: 1'b0};
  localparam mem_type_t STORE_SD = '{size: SIZE_D, sext: 1'b0};

  // True when an access of 2**size bytes at byte offset off spills past a bus word.
  function automatic logic crosses(input int unsigned off, input logic [1:0] size,
                                   input int unsigned nb);
    return (off + (32'd1 << size)) > nb;
  endfunction

endpackage

// File: rtl/ysyx_23060025_lsu_align.sv
// Combinational lane shifter: splits store mask/data across two beats and
// extracts/extends load data from the two-beat accumulator.
module ysyx_23060025_lsu_align
  import ysyx_23060025_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int NB       = DATA_LEN / 8,
  parameter int OFFW     = $clog2(NB)
) (
  input  logic [OFFW-1:0]       off,
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [DATA_LEN-1:0]   wdata,
  input  logic [2*DATA_LEN-1:0] acc,
  output logic [NB-1:0]         strb_lo,
  output logic [NB-1:0]         strb_hi,
  output logic [DATA_LEN-1:0]   wdata_lo,
  output logic [DATA_LEN-1:0]   wdata_hi,
  output logic [DATA_LEN-1:0]   rdata
);

  logic [2*NB-1:0]       base;
  logic [2*NB-1:0]       mask2;
  logic [2*DATA_LEN-1:0] data2;
  logic [2*DATA_LEN-1:0] sh;
  logic [DATA_LEN-1:0]   keep;
  logic [DATA_LEN-1:0]   low;
  logic                  sign;

  always_comb begin
    base  = (2*NB)'(8'h01);
    keep  = DATA_LEN'(8'hFF);
    sh    = acc >> {off, 3'b000};
    sign  = sh[7];
    case (size)
      SIZE_B: begin base = (2*NB)'(8'h01); keep = DATA_LEN'(8'hFF);         sign = sh[7];  end
      SIZE_H: begin base = (2*NB)'(8'h03); keep = DATA_LEN'(16'hFFFF);       sign = sh[15]; end
      SIZE_W: begin base = (2*NB)'(8'h0F); keep = DATA_LEN'(32'hFFFF_FFFF);  sign = sh[31]; end
      default: begin base = (2*NB)'(8'hFF); keep = '1;                       sign = sh[63]; end
    endcase
    mask2 = base << off;
    data2 = {{DATA_LEN{1'b0}}, wdata} << {off, 3'b000};
    low   = sh[DATA_LEN-1:0];
    rdata = (low & keep) | (~keep & {DATA_LEN{sext & sign}});
  end

  assign strb_lo  = mask2[NB-1:0];
  assign strb_hi  = mask2[2*NB-1:NB];
  assign wdata_lo = data2[DATA_LEN-1:0];
  assign wdata_hi = data2[2*DATA_LEN-1:DATA_LEN];

endmodule

// File: rtl/ysyx_23060025_lsu_split.sv
// Load/store unit core: issues one aligned beat, or two beats for accesses
// that cross a bus word, between the EXU and WBU handshakes.
module ysyx_23060025_lsu_split
  import ysyx_23060025_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int SPLIT_EN = 1,
  parameter int NB       = DATA_LEN / 8,
  parameter int OFFW     = $clog2(NB)
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_LEN-1:0] in_addr,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [1:0]          in_size,
  input  logic                in_sext,
  input  logic [DATA_LEN-1:0] in_wdata,
  input  logic [4:0]          in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_rdata,
  output logic [4:0]          out_rd,
  output logic                out_misalign,
  output logic [ADDR_LEN-1:0] out_paddr,
  output logic                out_psel,
  output logic                out_pwrite,
  output logic [2:0]          out_psize,
  output logic [DATA_LEN-1:0] out_pwdata,
  output logic [NB-1:0]       out_pwstrb,
  input  logic [DATA_LEN-1:0] out_prdata,
  input  logic                out_pvalid
);

  lsu_state_e            state, state_nxt, route_state;
  logic [ADDR_LEN-1:0]   req_addr;
  logic                  req_ren, req_wen, req_sext, req_cross;
  logic [1:0]            req_size;
  logic [DATA_LEN-1:0]   req_wdata;
  logic [4:0]            req_rd;
  logic                  misalign_q;
  logic [DATA_LEN-1:0]   rdata_q;
  logic [2*DATA_LEN-1:0] acc, acc_nxt;

  logic                  accept, beat_done, cross_in, mem_in;
  logic [ADDR_LEN-1:0]   base_addr;
  logic [NB-1:0]         strb_lo, strb_hi;
  logic [DATA_LEN-1:0]   wdata_lo, wdata_hi, align_rdata;

  assign cross_in  = crosses(32'(in_addr[OFFW-1:0]), in_size, NB);
  assign mem_in    = in_ren | in_wen;
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_psel  = (state == BEAT0) | (state == BEAT1);
  assign beat_done = out_psel & out_pvalid;
  assign base_addr = {req_addr[ADDR_LEN-1:OFFW], {OFFW{1'b0}}};

  always_comb begin
    route_state = BEAT0;
    if (!mem_in)                         route_state = DONE;
    else if (cross_in && SPLIT_EN == 0)  route_state = DONE;

    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = route_state;
      BEAT0: if (out_pvalid) state_nxt = req_cross ? BEAT1 : DONE;
      BEAT1: if (out_pvalid) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = accept ? route_state : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The aligner sees the accumulator as it will be after this beat, so the
  // final load result can be registered on the completing edge.
  always_comb begin
    acc_nxt = acc;
    if (state == BEAT0) acc_nxt = {{DATA_LEN{1'b0}}, out_prdata};
    if (state == BEAT1) acc_nxt = {out_prdata, acc[DATA_LEN-1:0]};
  end

  ysyx_23060025_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
    .off      (req_addr[OFFW-1:0]),
    .size     (req_size),
    .sext     (req_sext),
    .wdata    (req_wdata),
    .acc      (acc_nxt),
    .strb_lo  (strb_lo),
    .strb_hi  (strb_hi),
    .wdata_lo (wdata_lo),
    .wdata_hi (wdata_hi),
    .rdata    (align_rdata)
  );

  always_comb begin
    out_paddr  = '0;
    out_psize  = '0;
    out_pwdata = '0;
    out_pwstrb = '0;
    if (state == BEAT0) begin
      out_paddr  = req_cross ? base_addr : req_addr;
      out_psize  = req_cross ? 3'(OFFW) : {1'b0, req_size};
      out_pwdata = wdata_lo;
      out_pwstrb = strb_lo;
    end else if (state == BEAT1) begin
      out_paddr  = base_addr + ADDR_LEN'(NB);
      out_psize  = 3'(OFFW);
      out_pwdata = wdata_hi;
      out_pwstrb = strb_hi;
    end
  end

  assign out_pwrite   = req_wen & out_psel;
  assign out_valid    = (state == DONE);
  assign out_rdata    = rdata_q;
  assign out_rd       = req_rd;
  assign out_misalign = misalign_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_ren    <= 1'b0;
      req_wen    <= 1'b0;
      req_size   <= '0;
      req_sext   <= 1'b0;
      req_cross  <= 1'b0;
      req_wdata  <= '0;
      req_rd     <= '0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      acc        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_addr   <= in_addr;
        req_ren    <= in_ren;
        req_wen    <= in_wen;
        req_size   <= in_size;
        req_sext   <= in_sext;
        req_cross  <= cross_in;
        req_wdata  <= in_wdata;
        req_rd     <= in_rd;
        misalign_q <= mem_in & cross_in & (SPLIT_EN == 0);
        rdata_q    <= '0;
      end
      if (beat_done) begin
        acc <= acc_nxt;
        if (state == BEAT1 || !req_cross)
          rdata_q <= req_ren ? align_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_lsu_split.sv
// Directed bench for the split-capable LSU (DATA_LEN=32), with a second
// instance built with SPLIT_EN=0 for the crossing-rejection path.
module tb_ysyx_23060025_lsu_split;

  logic        clock, rstn;
  logic        in_valid, in_ren, in_wen, in_sext, out_ready, out_pvalid;
  logic [31:0] in_addr, in_wdata, out_prdata;
  logic [1:0]  in_size;
  logic [4:0]  in_rd;

  logic        in_ready, out_valid, out_misalign, out_psel, out_pwrite;
  logic [31:0] out_rdata, out_paddr, out_pwdata;
  logic [4:0]  out_rd;
  logic [2:0]  out_psize;
  logic [3:0]  out_pwstrb;

  logic        m_in_ready, m_out_valid, m_out_misalign, m_out_psel, m_out_pwrite;
  logic [31:0] m_out_rdata, m_out_paddr, m_out_pwdata;
  logic [4:0]  m_out_rd;
  logic [2:0]  m_out_psize;
  logic [3:0]  m_out_pwstrb;

  int errors = 0;
  int checks = 0;
  logic [31:0] held_rdata;

  ysyx_23060025_lsu_split #(.DATA_LEN(32), .ADDR_LEN(32), .SPLIT_EN(1)) dut (
    .clock(clock), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_ren(in_ren), .in_wen(in_wen), .in_size(in_size),
    .in_sext(in_sext), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_misalign(out_misalign), .out_paddr(out_paddr),
    .out_psel(out_psel), .out_pwrite(out_pwrite), .out_psize(out_psize),
    .out_pwdata(out_pwdata), .out_pwstrb(out_pwstrb), .out_prdata(out_prdata),
    .out_pvalid(out_pvalid)
  );

  ysyx_23060025_lsu_split #(.DATA_LEN(32), .ADDR_LEN(32), .SPLIT_EN(0)) dut_nosplit (
    .clock(clock), .rstn(rstn), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_addr(in_addr), .in_ren(in_ren), .in_wen(in_wen), .in_size(in_size),
    .in_sext(in_sext), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_rdata(m_out_rdata),
    .out_rd(m_out_rd), .out_misalign(m_out_misalign), .out_paddr(m_out_paddr),
    .out_psel(m_out_psel), .out_pwrite(m_out_pwrite), .out_psize(m_out_psize),
    .out_pwdata(m_out_pwdata), .out_pwstrb(m_out_pwstrb), .out_prdata(out_prdata),
    .out_pvalid(out_pvalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_ren = 0; in_wen = 0; in_sext = 0; in_size = 0;
    in_addr = 0; in_wdata = 0; in_rd = 0; out_ready = 1; out_pvalid = 0; out_prdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
    tick();
  endtask

  task automatic req(input logic [31:0] addr, input logic ren, input logic wen,
                     input logic [1:0] size, input logic sext,
                     input logic [31:0] wdata, input logic [4:0] rd);
    in_valid = 1; in_addr = addr; in_ren = ren; in_wen = wen;
    in_size = size; in_sext = sext; in_wdata = wdata; in_rd = rd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_psel !== 1'b0) begin errors++; $display("FAIL reset_psel got=%b exp=0", out_psel); end
    checks++; if (out_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", out_rdata); end
    tick();
    rstn = 1;
    tick();
  endtask

  task automatic test_aligned_load();
    do_reset();
    req(32'h8000_0010, 1, 0, 2'd2, 0, 0, 5'd7);
    out_pvalid = 1; out_prdata = 32'h0302_0100;
    tick();
    in_valid = 0;
    checks++; if (out_psel !== 1'b1) begin errors++; $display("FAIL lw_psel got=%b exp=1", out_psel); end
    checks++; if (out_paddr !== 32'h8000_0010) begin errors++; $display("FAIL lw_paddr got=%h exp=80000010", out_paddr); end
    checks++; if (out_psize !== 3'd2) begin errors++; $display("FAIL lw_psize got=%0d exp=2", out_psize); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_early_valid got=%b exp=0", out_valid); end
    tick();
    out_pvalid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got=%b exp=1", out_valid); end
    checks++; if (out_rdata !== 32'h0302_0100) begin errors++; $display("FAIL lw_rdata got=%h exp=03020100", out_rdata); end
    checks++; if (out_rd !== 5'd7) begin errors++; $display("FAIL lw_rd got=%0d exp=7", out_rd); end
    checks++; if (out_psel !== 1'b0) begin errors++; $display("FAIL lw_psel_done got=%b exp=0", out_psel); end
    tick();
  endtask

  task automatic test_byte_load();
    do_reset();
    req(32'h8000_0011, 1, 0, 2'd0, 0, 0, 5'd3);
    out_pvalid = 1; out_prdata = 32'h0000_F500;
    tick();
    in_valid = 0;
    checks++; if (out_paddr !== 32'h8000_0011) begin errors++; $display("FAIL lbu_paddr got=%h exp=80000011", out_paddr); end
    checks++; if (out_psize !== 3'd0) begin errors++; $display("FAIL lbu_psize got=%0d exp=0", out_psize); end
    tick();
    out_pvalid = 0;
    checks++; if (out_rdata !== 32'h0000_00F5) begin errors++; $display("FAIL lbu_rdata got=%h exp=000000f5", out_rdata); end
    tick();
  endtask

  task automatic test_split_load();
    do_reset();
    req(32'h8000_0013, 1, 0, 2'd1, 1, 0, 5'd9);
    tick();
    in_valid = 0;
    checks++; if (out_paddr !== 32'h8000_0010) begin errors++; $display("FAIL lh_b0_paddr got=%h exp=80000010", out_paddr); end
    checks++; if (out_psize !== 3'd2) begin errors++; $display("FAIL lh_b0_psize got=%0d exp=2", out_psize); end
    tick();
    checks++; if (out_paddr !== 32'h8000_0010 || out_psel !== 1'b1) begin errors++; $display("FAIL lh_b0_hold paddr=%h psel=%b exp=80000010/1", out_paddr, out_psel); end
    out_pvalid = 1; out_prdata = 32'hAB00_0000;
    tick();
    checks++; if (out_paddr !== 32'h8000_0014) begin errors++; $display("FAIL lh_b1_paddr got=%h exp=80000014", out_paddr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lh_b1_valid got=%b exp=0", out_valid); end
    out_prdata = 32'h0000_00CD;
    tick();
    out_pvalid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lh_valid got=%b exp=1", out_valid); end
    checks++; if (out_rdata !== 32'hFFFF_CDAB) begin errors++; $display("FAIL lh_rdata got=%h exp=ffffcdab", out_rdata); end
    tick();
  endtask

  task automatic test_split_store();
    do_reset();
    req(32'h8000_0012, 0, 1, 2'd2, 0, 32'h1122_3344, 5'd0);
    out_pvalid = 1; out_prdata = 0;
    tick();
    in_valid = 0;
    checks++; if (out_paddr !== 32'h8000_0010) begin errors++; $display("FAIL sw_b0_paddr got=%h exp=80000010", out_paddr); end
    checks++; if (out_pwstrb !== 4'b1100) begin errors++; $display("FAIL sw_b0_strb got=%b exp=1100", out_pwstrb); end
    checks++; if (out_pwdata !== 32'h3344_0000) begin errors++; $display("FAIL sw_b0_data got=%h exp=33440000", out_pwdata); end
    checks++; if (out_pwrite !== 1'b1) begin errors++; $display("FAIL sw_b0_pwrite got=%b exp=1", out_pwrite); end
    tick();
    checks++; if (out_paddr !== 32'h8000_0014) begin errors++; $display("FAIL sw_b1_paddr got=%h exp=80000014", out_paddr); end
    checks++; if (out_pwstrb !== 4'b0011) begin errors++; $display("FAIL sw_b1_strb got=%b exp=0011", out_pwstrb); end
    checks++; if (out_pwdata !== 32'h0000_1122) begin errors++; $display("FAIL sw_b1_data got=%h exp=00001122", out_pwdata); end
    tick();
    out_pvalid = 0;
    checks++; if (out_valid !== 1'b1 || out_rdata !== 32'h0) begin errors++; $display("FAIL sw_done valid=%b rdata=%h exp=1/0", out_valid, out_rdata); end
    tick();
  endtask

  task automatic test_misalign();
    do_reset();
    req(32'h8000_0012, 0, 1, 2'd2, 0, 32'h1122_3344, 5'd0);
    tick();
    in_valid = 0;
    checks++; if (m_out_psel !== 1'b0) begin errors++; $display("FAIL nosplit_psel got=%b exp=0", m_out_psel); end
    checks++; if (m_out_valid !== 1'b1) begin errors++; $display("FAIL nosplit_valid got=%b exp=1", m_out_valid); end
    checks++; if (m_out_misalign !== 1'b1) begin errors++; $display("FAIL nosplit_misalign got=%b exp=1", m_out_misalign); end
    checks++; if (out_misalign !== 1'b0 || out_psel !== 1'b1) begin errors++; $display("FAIL split_no_misalign misalign=%b psel=%b exp=0/1", out_misalign, out_psel); end
  endtask

  task automatic test_nonmem();
    do_reset();
    req(32'h8000_0013, 0, 0, 2'd2, 0, 0, 5'd12);
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_psel !== 1'b0) begin errors++; $display("FAIL nonmem valid=%b psel=%b exp=1/0", out_valid, out_psel); end
    checks++; if (out_rdata !== 32'h0 || out_rd !== 5'd12) begin errors++; $display("FAIL nonmem_data rdata=%h rd=%0d exp=0/12", out_rdata, out_rd); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 0;
    req(32'h8000_0010, 1, 0, 2'd2, 0, 0, 5'd4);
    out_pvalid = 1; out_prdata = 32'hCAFE_F00D;
    tick();
    in_valid = 0;
    tick();
    out_pvalid = 0;
    held_rdata = out_rdata;
    checks++; if (held_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_rdata got=%h exp=cafef00d", held_rdata); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rdata !== 32'hCAFE_F00D || out_rd !== 5'd4)
        begin errors++; $display("FAIL bp_hold%0d valid=%b in_ready=%b rdata=%h rd=%0d", i, out_valid, in_ready, out_rdata, out_rd); end
    end
    out_ready = 1;
    req(32'h8000_0020, 0, 1, 2'd2, 0, 32'hDEAD_BEEF, 5'd0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_psel !== 1'b1 || out_pwrite !== 1'b1 || out_paddr !== 32'h8000_0020)
      begin errors++; $display("FAIL b2b_beat psel=%b pwrite=%b paddr=%h exp=1/1/80000020", out_psel, out_pwrite, out_paddr); end
    checks++; if (out_pwstrb !== 4'hF || out_pwdata !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL b2b_data strb=%h data=%h exp=f/deadbeef", out_pwstrb, out_pwdata); end
  endtask

  task automatic test_reset_mid_beat();
    do_reset();
    req(32'h8000_0013, 1, 0, 2'd1, 1, 0, 5'd1);
    out_pvalid = 1; out_prdata = 32'hAB00_0000;
    tick();
    in_valid = 0;
    tick();
    checks++; if (out_psel !== 1'b1 || out_paddr !== 32'h8000_0014) begin errors++; $display("FAIL rst_pre psel=%b paddr=%h exp=1/80000014", out_psel, out_paddr); end
    out_pvalid = 0;
    #1;
    rstn = 0;
    #1;
    checks++; if (out_psel !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid psel=%b valid=%b exp=0/0", out_psel, out_valid); end
    tick();
    rstn = 1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_psel !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rst_after in_ready=%b psel=%b valid=%b exp=1/0/0", in_ready, out_psel, out_valid); end
  endtask

  initial begin
    idle_inputs();
    rstn = 1;
    test_reset();
    test_aligned_load();
    test_byte_load();
    test_split_load();
    test_split_store();
    test_misalign();
    test_nonmem();
    test_back_to_back();
    test_reset_mid_beat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
